i2c_slave_regs: RTL

- Synthesizable I2C slave (responder): the far end of the bus driven by the APB-controlled I2C master; replaces the behavioural slave model in silicon.
- Oversamples SCL/SDA on the core clock, detects START/STOP, matches a 7-bit address and serves a small byte register file.
- Register file uses an auto-incrementing pointer: standard "pointer byte, then data" write and pointer-relative read.
- Drives SDA open-drain via an output-enable only; no clock stretching.

---
 rtl/i2c_slave_regs.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regs.sv
// I2C slave responder with a 2**PTR_WIDTH byte register file: "pointer, then data"
// writes and pointer-relative reads, both auto-incrementing. SDA is driven open-drain.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         PTR_WIDTH  = 4
) (
    input  logic                 i2c_core_clock_i,
    input  logic                 i2c_core_reset_i,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 sda_oe_o,
    output logic                 busy_o,
    output logic                 wr_strobe_o,
    output logic [PTR_WIDTH-1:0] wr_addr_o,
    output logic [7:0]           wr_data_o
);
    localparam int DEPTH = 2 ** PTR_WIDTH;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    // [0] metastable stage, [1] synchronised sample, [2] previous synchronised sample
    logic [2:0]           scl_q, sda_q;
    logic [1:0]           settle;
    state_t               state, state_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic [7:0]           shift, shift_n;
    logic [PTR_WIDTH-1:0] ptr, ptr_n;
    logic                 sda_oe_n, busy_n, strobe_n, mem_we;
    logic [PTR_WIDTH-1:0] waddr_n;
    logic [7:0]           wdata_n;
    logic [7:0]           mem [DEPTH];

    logic       scl_rise, scl_fall, start_det, stop_det, line_ok;
    logic [7:0] rx_byte, rd_byte;

    // The chains restart at 1 after reset; mask START/STOP until they hold real bus
    // samples so a low SDA at reset release is not mistaken for a START.
    assign line_ok   = (settle == 2'd3);
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = line_ok & scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_det  = line_ok & scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign rx_byte   = {shift[6:0], sda_q[1]};
    assign rd_byte   = mem[ptr];

    always_ff @(posedge i2c_core_clock_i) begin
        if (i2c_core_reset_i) begin
            scl_q       <= '1;
            sda_q       <= '1;
            settle      <= '0;
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            ptr         <= '0;
            sda_oe_o    <= 1'b0;
            busy_o      <= 1'b0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            // NOTE: register bytes are architecturally reset to zero, so this array must be flops, not a RAM.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            scl_q       <= {scl_q[1:0], scl_i};
            sda_q       <= {sda_q[1:0], sda_i};
            if (!line_ok) settle <= settle + 2'd1;
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            ptr         <= ptr_n;
            sda_oe_o    <= sda_oe_n;
            busy_o      <= busy_n;
            wr_strobe_o <= strobe_n;
            wr_addr_o   <= waddr_n;
            wr_data_o   <= wdata_n;
            if (mem_we) mem[ptr] <= rx_byte;
        end
    end

    always_comb begin
        // NOTE: every variable is defaulted first so no latch is inferred on unassigned paths.
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ptr_n     = ptr;
        sda_oe_n  = sda_oe_o;
        busy_n    = busy_o;
        strobe_n  = 1'b0;
        waddr_n   = wr_addr_o;
        wdata_n   = wr_data_o;
        mem_we    = 1'b0;

        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end
                    end
                end
                PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == PTR) begin
                                ptr_n   = rx_byte[PTR_WIDTH-1:0];
                                state_n = PTR_ACK;
                            end else begin
                                mem_we   = 1'b1;
                                strobe_n = 1'b1;
                                waddr_n  = ptr;
                                wdata_n  = rx_byte;
                                ptr_n    = ptr + PTR_WIDTH'(1);
                                state_n  = WDATA_ACK;
                            end
                        end
                    end
                end
                // bit_cnt 0: waiting for the 8th fall; 1: ACK driven, waiting for the 9th fall
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_n  = 1'b1;
                            bit_cnt_n = 3'd1;
                        end else begin
                            bit_cnt_n = '0;
                            sda_oe_n  = 1'b0;
                            if (state == ADDR_ACK && shift[0]) begin
                                shift_n  = rd_byte;
                                sda_oe_n = ~rd_byte[7];
                                state_n  = RDATA;
                            end else if (state == ADDR_ACK) begin
                                state_n = PTR;
                            end else begin
                                state_n = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_n = '0;
                            sda_oe_n  = 1'b0;
                            ptr_n     = ptr + PTR_WIDTH'(1);
                            state_n   = RDATA_ACK;
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                            shift_n   = {shift[6:0], 1'b0};
                            sda_oe_n  = ~shift[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_q[1]) begin
                            state_n = WAIT_STOP;
                            busy_n  = 1'b0;
                        end else begin
                            bit_cnt_n = 3'd1;
                        end
                    end else if (scl_fall && bit_cnt == 3'd1) begin
                        bit_cnt_n = '0;
                        shift_n   = rd_byte;
                        sda_oe_n  = ~rd_byte[7];
                        state_n   = RDATA;
                    end
                end
                IDLE, WAIT_STOP: sda_oe_n = 1'b0;
                default: begin
                    state_n  = IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule
